// File: rtl/bg_tile_fetch_seq_pkg.sv
// Shared types and constants for the background tile fetch sequencer.
// Provides the FSM state encoding and the pattern-table address builder.
package bg_tile_fetch_seq_pkg;

  localparam int BG_TILES  = 33;
  localparam int BG_ADDR_W = 16;

  localparam logic [15:0] PT_BASE_0  = 16'h0000;
  localparam logic [15:0] PT_BASE_1  = 16'h1000;
  localparam logic [15:0] TILE_BYTES = 16'd16;
  localparam logic [15:0] PLANE_OFS  = 16'd8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_NT_RD,
    S_PTL_RD,
    S_PTH_RD,
    S_OUT,
    S_DONE
  } fetch_state_e;

  // Each tile owns 16 bytes: 8 rows of plane 0 followed by 8 rows of plane 1.
  function automatic logic [15:0] pt_addr(input logic       sel,
                                          input logic [7:0] tile,
                                          input logic       plane,
                                          input logic [2:0] fine);
    logic [15:0] base;
    base = sel ? PT_BASE_1 : PT_BASE_0;
    return base + ({8'h00, tile} * TILE_BYTES) + (plane ? PLANE_OFS : 16'd0) + {13'd0, fine};
  endfunction

endpackage

// File: rtl/bg_tile_fetch_seq_if.sv
// VRAM read port and tile hand-off port of the background fetch sequencer.
// master = sequencer side, slave = VRAM arbiter / background shifter side.
interface bg_tile_fetch_seq_if
  import bg_tile_fetch_seq_pkg::*;
#(
  parameter int ADDR_W = BG_ADDR_W
);
  logic              vram_req;
  logic [ADDR_W-1:0] vram_addr;
  logic              vram_ack;
  logic [7:0]        vram_rdata;
  logic              tile_valid;
  logic              tile_ready;
  logic [7:0]        tile_lo;
  logic [7:0]        tile_hi;
  logic [5:0]        tile_idx;

  modport master (
    output vram_req, vram_addr, tile_valid, tile_lo, tile_hi, tile_idx,
    input  vram_ack, vram_rdata, tile_ready
  );

  modport slave (
    input  vram_req, vram_addr, tile_valid, tile_lo, tile_hi, tile_idx,
    output vram_ack, vram_rdata, tile_ready
  );
endinterface

// File: rtl/bg_tile_fetch_seq_vram_rd_port.sv
// Single-transaction VRAM read holder: go loads req/addr, which stay put until ack.
// A go in the ack cycle chains the next read with no idle cycle between them.
module bg_tile_fetch_seq_vram_rd_port
  import bg_tile_fetch_seq_pkg::*;
#(
  parameter int ADDR_W = BG_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              go_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic              ack_i,
  input  logic [7:0]        rdata_i,
  output logic              req_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic              done_o,
  output logic [7:0]        data_o
);

  logic              req_q;
  logic [ADDR_W-1:0] addr_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      req_q  <= 1'b0;
      addr_q <= '0;
    end else if (go_i) begin
      req_q  <= 1'b1;
      addr_q <= addr_i;
    end else if (req_q && ack_i) begin
      req_q  <= 1'b0;
    end
  end

  // An ack arriving with no request outstanding is ignored.
  assign done_o = req_q & ack_i;
  assign data_o = rdata_i;
  assign req_o  = req_q;
  assign addr_o = addr_q;

endmodule

// File: rtl/bg_tile_fetch_seq.sv
// Per-scanline background tile fetch sequencer: for each tile column it reads the
// nametable byte and both pattern planes over VRAM, then offers the row to the shifter.
module bg_tile_fetch_seq
  import bg_tile_fetch_seq_pkg::*;
#(
  parameter int TILES  = BG_TILES,
  parameter int ADDR_W = BG_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic              abort_i,
  input  logic [8:0]        scanline_i,
  input  logic [7:0]        ppu_ctrl1_i,
  output logic [8:0]        xlat_row_o,
  output logic [8:0]        xlat_col_o,
  input  logic [ADDR_W-1:0] xlat_nt_ptr_i,
  input  logic [2:0]        xlat_fine_i,
  bg_tile_fetch_seq_if.master bus,
  output logic              busy_o,
  output logic              done_o
);

  localparam logic [5:0] LAST_IDX = 6'(TILES - 1);

  fetch_state_e state_q;
  logic [8:0]   row_q, col_q;
  logic         sel_q;
  logic [2:0]   fine_q;
  logic [7:0]   tile_q;
  logic [7:0]   tile_lo_q, tile_hi_q;
  logic [5:0]   tile_idx_q;
  logic         tile_valid_q;
  logic         busy_q, done_q, abort_q;

  logic              rd_go, rd_done;
  logic [ADDR_W-1:0] rd_addr;
  logic [7:0]        rd_data;
  logic              abort_any;

  logic unused_ctrl_bits;
  assign unused_ctrl_bits = ^{ppu_ctrl1_i[7:5], ppu_ctrl1_i[3:0]};

  assign abort_any = abort_i | abort_q;

  // Each read is launched in the cycle that enters its RD state, so the port registers it on that edge.
  always_comb begin
    rd_go   = 1'b0;
    rd_addr = xlat_nt_ptr_i;
    case (state_q)
      S_SETUP: rd_go = !abort_i;
      S_NT_RD: begin
        if (rd_done && !abort_any) begin
          rd_go   = 1'b1;
          rd_addr = ADDR_W'(pt_addr(sel_q, rd_data, 1'b0, fine_q));
        end
      end
      S_PTL_RD: begin
        if (rd_done && !abort_any) begin
          rd_go   = 1'b1;
          rd_addr = ADDR_W'(pt_addr(sel_q, tile_q, 1'b1, fine_q));
        end
      end
      default: ;
    endcase
  end

  bg_tile_fetch_seq_vram_rd_port #(.ADDR_W(ADDR_W)) u_rd_port (
    .clk     (clk),
    .rst_n   (rst_n),
    .go_i    (rd_go),
    .addr_i  (rd_addr),
    .ack_i   (bus.vram_ack),
    .rdata_i (bus.vram_rdata),
    .req_o   (bus.vram_req),
    .addr_o  (bus.vram_addr),
    .done_o  (rd_done),
    .data_o  (rd_data)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      row_q        <= '0;
      col_q        <= '0;
      sel_q        <= 1'b0;
      fine_q       <= '0;
      tile_q       <= '0;
      tile_lo_q    <= '0;
      tile_hi_q    <= '0;
      tile_idx_q   <= '0;
      tile_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      abort_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start_i && !abort_i) begin
            row_q      <= scanline_i;
            col_q      <= '0;
            sel_q      <= ppu_ctrl1_i[4];
            tile_idx_q <= '0;
            busy_q     <= 1'b1;
            abort_q    <= 1'b0;
            state_q    <= S_SETUP;
          end
        end
        S_SETUP: begin
          if (abort_i) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else begin
            fine_q  <= xlat_fine_i;
            state_q <= S_NT_RD;
          end
        end
        S_NT_RD: begin
          if (abort_i) abort_q <= 1'b1;
          if (rd_done) begin
            tile_q <= rd_data;
            if (abort_any) begin
              abort_q <= 1'b0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end else begin
              state_q <= S_PTL_RD;
            end
          end
        end
        S_PTL_RD: begin
          if (abort_i) abort_q <= 1'b1;
          if (rd_done) begin
            tile_lo_q <= rd_data;
            if (abort_any) begin
              abort_q <= 1'b0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end else begin
              state_q <= S_PTH_RD;
            end
          end
        end
        S_PTH_RD: begin
          if (abort_i) abort_q <= 1'b1;
          if (rd_done) begin
            tile_hi_q <= rd_data;
            if (abort_any) begin
              abort_q <= 1'b0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end else begin
              tile_valid_q <= 1'b1;
              state_q      <= S_OUT;
            end
          end
        end
        S_OUT: begin
          // Abort wins over a simultaneous ready: the tile is withdrawn, not handed over.
          if (abort_i) begin
            tile_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b1;
            state_q      <= S_DONE;
          end else if (bus.tile_ready) begin
            tile_valid_q <= 1'b0;
            if (tile_idx_q == LAST_IDX) begin
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end else begin
              tile_idx_q <= tile_idx_q + 6'd1;
              col_q      <= col_q + 9'd8;
              state_q    <= S_SETUP;
            end
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign xlat_row_o     = row_q;
  assign xlat_col_o     = col_q;
  assign bus.tile_valid = tile_valid_q;
  assign bus.tile_lo    = tile_lo_q;
  assign bus.tile_hi    = tile_hi_q;
  assign bus.tile_idx   = tile_idx_q;
  assign busy_o         = busy_q;
  assign done_o         = done_q;

endmodule
